resize_interp_unit: RTL and testbench
=====================================

Name: resize_interp_unit

Overview:
- Bilinear-resize datapath that sits directly downstream of resize_controller.
- Accepts one job at a time: src_addr1, src_addr2, des_addr, fraction_part, stage_flag.
- Reads the two source pixels from feature-map RAM, computes the linear interpolation p1 + frac*(p2-p1), and writes the result to des_addr.
- Two passes (stage_flag 0 = horizontal into the intermediate buffer, 1 = vertical into the output buffer) make a full bilinear resize.

Parameters:
- ADDR_SZ, 18, address width; matches the controller address width.
- DATA_W, 16, unsigned pixel width.
- FRAC_W, 16, fraction width; unsigned Q0.FRAC_W, range [0,1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  job valid from the controller.
- in_ready  out  1  unit can accept a job.
- in_last  in  1  job is the final one of the pass (controller done).
- src_addr1  in  ADDR_SZ  address of left/top source pixel.
- src_addr2  in  ADDR_SZ  address of right/bottom source pixel.
- des_addr  in  ADDR_SZ  destination address.
- fraction_part  in  FRAC_W  interpolation weight of pixel 2.
- stage_flag  in  1  pass select, forwarded to the write port.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_SZ  RAM read address.
- rd_data  in  DATA_W  RAM read data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  write request.
- wr_ready  in  1  write accepted by the arbiter.
- wr_addr  out  ADDR_SZ  write address.
- wr_data  out  DATA_W  interpolated pixel.
- wr_stage  out  1  latched stage_flag of the job being written.
- done  out  1  1-cycle pulse after the in_last job's write is accepted.

Behaviour:
- Reset (async, any time incl. mid-job):
  - FSM to IDLE; all outputs and internal registers 0.
  - In-flight job discarded; no write issued.
  - in_ready rises on the first clock after reset deasserts.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid & in_ready, latch addr1/addr2/des/frac/stage/last; go to RD1.
  - RD1: rd_en=1, rd_addr=addr1. If addr1==addr2, go to CAP; else go to RD2.
  - RD2: rd_en=1, rd_addr=addr2. Capture p1 <= rd_data. Go to CAP.
  - CAP: p2 <= rd_data. In the equal-address case, p1 <= rd_data as well. Go to CALC.
  - CALC: result register loaded (see arithmetic). Go to WR.
  - WR: wr_en=1; wr_addr/wr_data/wr_stage held stable.
    - Stay in WR while wr_ready=0.
    - On wr_en & wr_ready, go to IDLE; if last was latched, done=1 in the following cycle.
- in_ready is 1 only in IDLE. Inputs are ignored in all other states. No input buffering; the controller holds its job until accepted.
- rd_en and wr_en are never high in the same cycle.
- Latency (wr_ready tied 1), job accepted at edge T:
  - Normal job: wr_en high in cycle T+5; throughput 1 job per 6 cycles.
  - addr1==addr2: wr_en high in cycle T+4.
- Arithmetic:
  - diff = signed(p2) - signed(p1), DATA_W+1 bits.
  - prod = diff * frac, signed, DATA_W+FRAC_W+1 bits.
  - q = (prod + 2^(FRAC_W-1)) >>> FRAC_W, arithmetic shift (round half up).
  - result = p1 + q, truncated to DATA_W. Always lies within [min(p1,p2), max(p1,p2)]; no saturation needed.
- Boundary cases:
  - frac=0 gives result=p1.
  - p1==p2 gives result=p1 for any frac.
- done never asserts for a job without in_last; done and in_ready=1 may coincide.
- wr_stage follows the latched stage_flag, not the live input.

Test Plan:
- Reset, then job p1@0x10=100, p2@0x11=200, frac=0x8000, des=0x200, stage=0 -> single write 150 to 0x200 with wr_stage=0 at T+5; done stays 0.
- p1=200, p2=100, frac=0x4000, stage=1, in_last=1 -> write 175, wr_stage=1; done pulses once, 1 cycle after the write is accepted.
- p1=0, p2=3, frac=0x8000 -> 2 (rounding). frac=0 -> p1. frac=0xFFFF with p1=0, p2=65535 -> 65534.
- src_addr1==src_addr2=0x40 holding 77, frac=0x1234 -> exactly one rd_en pulse; write 77 at T+4.
- wr_ready held 0 for 3 cycles -> wr_en/addr/data stable throughout; in_ready stays 0; single write on release.
- Assert reset during RD2 -> all outputs 0 immediately (asynchronous); no write or done; next job after release completes correctly.

Source files
------------

// File: rtl/resize_interp_unit.sv
// rtl/resize_interp_unit.sv - two-tap linear interpolation step of a bilinear resize, one job at a time
module resize_interp_unit #(
    parameter int ADDR_SZ = 18,
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [ADDR_SZ-1:0] src_addr1,
    input  logic [ADDR_SZ-1:0] src_addr2,
    input  logic [ADDR_SZ-1:0] des_addr,
    input  logic [FRAC_W-1:0]  fraction_part,
    input  logic               stage_flag,
    output logic               rd_en,
    output logic [ADDR_SZ-1:0] rd_addr,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               wr_en,
    input  logic               wr_ready,
    output logic [ADDR_SZ-1:0] wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               wr_stage,
    output logic               done
);

    localparam int PW = DATA_W + FRAC_W + 2;
    localparam logic signed [PW-1:0] HALF = $signed(PW'(1) << (FRAC_W - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD1,
        S_RD2,
        S_CAP,
        S_CALC,
        S_WR
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_SZ-1:0] addr1_q, addr1_d;
    logic [ADDR_SZ-1:0] addr2_q, addr2_d;
    logic [ADDR_SZ-1:0] des_q, des_d;
    logic [FRAC_W-1:0]  frac_q, frac_d;
    logic               stage_q, stage_d;
    logic               last_q, last_d;
    logic [DATA_W-1:0]  p1_q, p1_d;
    logic [DATA_W-1:0]  p2_q, p2_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               done_q, done_d;
    logic               init_q, init_d;

    logic                same_addr;
    logic                accept;
    logic signed [DATA_W:0] diff;
    logic signed [FRAC_W:0] frac_s;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   rnd;
    logic signed [PW-1:0]   q_full;
    logic signed [PW-1:0]   res_full;

    assign same_addr = (addr1_q == addr2_q);
    assign accept    = in_valid && in_ready;

    // Round-half-up via bias then arithmetic shift; |q| <= |diff| so p1+q never leaves [0, 2^DATA_W).
    always_comb begin
        diff     = $signed({1'b0, p2_q}) - $signed({1'b0, p1_q});
        frac_s   = $signed({1'b0, frac_q});
        prod     = PW'(diff) * PW'(frac_s);
        rnd      = prod + HALF;
        q_full   = rnd >>> FRAC_W;
        res_full = $signed(PW'(p1_q)) + q_full;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_RD1;
            S_RD1:  state_d = same_addr ? S_CAP : S_RD2;
            S_RD2:  state_d = S_CAP;
            S_CAP:  state_d = S_CALC;
            S_CALC: state_d = S_WR;
            S_WR:   if (wr_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // init_q keeps in_ready low until the first clock after reset releases.
    always_comb begin
        in_ready = (state_q == S_IDLE) && init_q;
        rd_en    = (state_q == S_RD1) || (state_q == S_RD2);
        rd_addr  = '0;
        if (state_q == S_RD1) rd_addr = addr1_q;
        if (state_q == S_RD2) rd_addr = addr2_q;
        wr_en    = (state_q == S_WR);
        wr_addr  = des_q;
        wr_data  = result_q;
        wr_stage = stage_q;
        done     = done_q;
    end

    always_comb begin
        addr1_d  = addr1_q;
        addr2_d  = addr2_q;
        des_d    = des_q;
        frac_d   = frac_q;
        stage_d  = stage_q;
        last_d   = last_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        result_d = result_q;
        init_d   = 1'b1;
        done_d   = (state_q == S_WR) && wr_ready && last_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr1_d = src_addr1;
                    addr2_d = src_addr2;
                    des_d   = des_addr;
                    frac_d  = fraction_part;
                    stage_d = stage_flag;
                    last_d  = in_last;
                end
            end
            S_RD2: p1_d = rd_data;
            S_CAP: begin
                p2_d = rd_data;
                if (same_addr) p1_d = rd_data;
            end
            S_CALC: result_d = DATA_W'(res_full);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr1_q  <= '0;
            addr2_q  <= '0;
            des_q    <= '0;
            frac_q   <= '0;
            stage_q  <= 1'b0;
            last_q   <= 1'b0;
            p1_q     <= '0;
            p2_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            addr1_q  <= addr1_d;
            addr2_q  <= addr2_d;
            des_q    <= des_d;
            frac_q   <= frac_d;
            stage_q  <= stage_d;
            last_q   <= last_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            result_q <= result_d;
            done_q   <= done_d;
            init_q   <= init_d;
        end
    end

endmodule

// File: tb/tb_resize_interp_unit.sv
// tb/tb_resize_interp_unit.sv - self-checking bench for resize_interp_unit
module tb_resize_interp_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [17:0] src_addr1 = '0;
    logic [17:0] src_addr2 = '0;
    logic [17:0] des_addr = '0;
    logic [15:0] fraction_part = '0;
    logic        stage_flag = 1'b0;
    logic        rd_en;
    logic [17:0] rd_addr;
    logic [15:0] rd_data = '0;
    logic        wr_en;
    logic        wr_ready = 1'b1;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_stage;
    logic        done;

    resize_interp_unit #(.ADDR_SZ(18), .DATA_W(16), .FRAC_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .src_addr1(src_addr1), .src_addr2(src_addr2), .des_addr(des_addr),
        .fraction_part(fraction_part), .stage_flag(stage_flag),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_stage(wr_stage), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] addr;
        int          data;
        logic        stage;
        logic        last;
        int          nrd;
        int          lat;
        int          acc;
        int          lit;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem [0:1023];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          since = 0;
    int          rd_cnt = 0;
    int          writes = 0;
    int          dones = 0;
    logic        done_pend = 1'b0;
    logic        prev_wen = 1'b0;
    logic        prev_wrdy = 1'b0;
    logic [17:0] prev_waddr = '0;
    logic [15:0] prev_wdata = '0;
    logic        prev_wstage = 1'b0;

    // p1 + round_half_up((p2-p1)*frac / 2^16), using floor division on exact integers.
    function automatic int model(int p1, int p2, int frac);
        longint num, q;
        num = longint'(p2 - p1) * longint'(frac) + 64'sd32768;
        if (num >= 0) q = num / 65536;
        else q = -((-num + 65535) / 65536);
        return int'(longint'(p1) + q);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr[9:0]] : 16'hDEAD;
    always @(posedge clk or posedge reset) begin
        if (reset) since <= 0;
        else if (since < 1000) since <= since + 1;
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_quiet", {rd_en, wr_en, done}, 0);
            sb.delete();
            done_pend = 1'b0;
            rd_cnt = 0;
            prev_wen = 1'b0;
        end else begin
            chk("rd_wr_exclusive", rd_en && wr_en, 0);
            chk("in_ready", in_ready, (since >= 1) && (sb.size() == 0));
            chk("done", done, done_pend);
            if (done) dones++;
            done_pend = 1'b0;
            if (rd_en) rd_cnt++;
            if (wr_en) begin
                if (sb.size() == 0) begin
                    chk("spurious_write", 1, 0);
                end else begin
                    if (!prev_wen) chk("latency", cyc - sb[0].acc, sb[0].lat);
                    if (prev_wen && !prev_wrdy) begin
                        chk("hold_addr", wr_addr, prev_waddr);
                        chk("hold_data", wr_data, prev_wdata);
                        chk("hold_stage", wr_stage, prev_wstage);
                    end
                    if (wr_ready) begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("wr_addr", wr_addr, e.addr);
                        chk("wr_data", wr_data, e.data);
                        chk("wr_stage", wr_stage, e.stage);
                        chk("rd_count", rd_cnt, e.nrd);
                        if (e.lit >= 0) chk("wr_data_literal", wr_data, e.lit);
                        done_pend = e.last;
                        rd_cnt = 0;
                        writes++;
                    end
                end
            end
            prev_wen    = wr_en;
            prev_wrdy   = wr_ready;
            prev_waddr  = wr_addr;
            prev_wdata  = wr_data;
            prev_wstage = wr_stage;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_job(input int a1, input int a2, input int des, input int frac,
                            input logic stage, input logic last, input int lit);
        exp_t e;
        int   n;
        int   acc;
        in_valid      = 1'b1;
        src_addr1     = 18'(a1);
        src_addr2     = 18'(a2);
        des_addr      = 18'(des);
        fraction_part = 16'(frac);
        stage_flag    = stage;
        in_last       = last;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", in_ready, 1);
        acc = cyc;
        @(posedge clk); #1;
        e.addr  = 18'(des);
        e.data  = model(int'(mem[a1]), int'(mem[a2]), frac);
        e.stage = stage;
        e.last  = last;
        e.nrd   = (a1 == a2) ? 1 : 2;
        e.lat   = (a1 == a2) ? 4 : 5;
        e.acc   = acc;
        e.lit   = lit;
        sb.push_back(e);
        in_valid      = 1'b0;
        src_addr1     = 18'h3FF;
        src_addr2     = 18'h3FE;
        des_addr      = 18'h3FD;
        fraction_part = 16'hAAAA;
        stage_flag    = ~stage;
        in_last       = ~last;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 37);
        mem[10'h10] = 16'd100;   mem[10'h11] = 16'd200;
        mem[10'h20] = 16'd200;   mem[10'h21] = 16'd100;
        mem[10'h30] = 16'd0;     mem[10'h31] = 16'd3;
        mem[10'h32] = 16'd0;     mem[10'h33] = 16'd65535;
        mem[10'h40] = 16'd77;

        #2 reset = 1'b1;
        #1;
        chk("reset_outputs", {in_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_stage, done}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("ready_before_first_clk", in_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_first_clk", in_ready, 1);

        send_job('h10, 'h11, 'h200, 'h8000, 1'b0, 1'b0, 150);
        send_job('h20, 'h21, 'h201, 'h4000, 1'b1, 1'b1, 175);
        send_job('h30, 'h31, 'h202, 'h8000, 1'b0, 1'b0, 2);
        send_job('h30, 'h31, 'h203, 'h0000, 1'b1, 1'b0, 0);
        send_job('h32, 'h33, 'h204, 'hFFFF, 1'b0, 1'b0, 65534);
        send_job('h40, 'h40, 'h205, 'h1234, 1'b1, 1'b1, 77);
        wait_idle();

        // Arbiter back-pressure: write must hold for three cycles.
        wr_ready = 1'b0;
        send_job('h10, 'h11, 'h206, 'h4000, 1'b1, 1'b0, 125);
        begin
            int n;
            n = 0;
            while (!wr_en && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("stall_wr_seen", wr_en, 1);
        end
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_wr_en", wr_en, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        wr_ready = 1'b1;
        wait_idle();

        // Reset lands while the unit is in RD2; the job must vanish.
        send_job('h20, 'h21, 'h207, 'h4000, 1'b1, 1'b1, 175);
        @(posedge clk); #1;
        chk("rd2_addr", rd_addr, 'h21);
        reset = 1'b1;
        #1;
        chk("midjob_reset_outputs", {in_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_stage, done}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        send_job('h10, 'h11, 'h208, 'h8000, 1'b0, 1'b1, 150);
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        chk("total_writes", writes, 8);
        chk("total_dones", dones, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
